// File: rtl/pixel_writer_pkg.sv
// Shared types and defaults for the rasterizer back-end.
//   Point2D  : signed screen coordinate produced by the line engine
//   FbWrite  : one framebuffer write {addr, color} at the default widths
//   PwState  : pixel_writer control states
//   PW_*     : default screen geometry and bus widths
package pixel_writer_pkg;

  localparam int PW_SCREEN_W = 640;
  localparam int PW_SCREEN_H = 480;
  localparam int PW_ADDR_W   = 19;
  localparam int PW_COLOR_W  = 8;

  typedef struct packed {
    shortint x;
    shortint y;
  } Point2D;

  typedef struct packed {
    logic [PW_ADDR_W-1:0]  addr;
    logic [PW_COLOR_W-1:0] color;
  } FbWrite;

  typedef enum logic [1:0] {
    RUN,
    CLEAR_WAIT,
    CLEAR
  } PwState;

  // Signed bounds test; coordinates are sign-extended before comparing
  // against the (int) screen size.
  function automatic logic on_screen(input shortint x, input shortint y,
                                     input int w, input int h);
    return (x >= 0) && (int'(x) < w) && (y >= 0) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/pixel_writer_fifo.sv
// pixel_fifo: synchronous FIFO with first and second entry look-ahead.
//   clk, n_rst     : clock, asynchronous active-low reset
//   push, wr_data  : write an entry (ignored when full unless popping)
//   pop            : retire the head entry (ignored when empty)
//   rd_data        : head entry
//   rd_next        : entry behind the head (valid when count >= 2)
//   full, empty    : occupancy flags
//   count          : number of stored entries
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [WIDTH-1:0]       rd_next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem[rd_ptr];
  assign rd_next = mem[rd_ptr + PTR_ONE];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: clips line-engine points, converts them to linear
// framebuffer addresses, buffers them and writes them over req/ack.
// Also performs a full-screen clear with a background colour.
//   clk, n_rst            : clock, asynchronous active-low reset
//   plot, point, color    : pixel stream from the line engine
//   clear_start/_color    : request a full-screen clear with this colour
//   mem_we/addr/data      : registered write request, held until mem_ack
//   mem_ack               : write accepted (only meaningful with mem_we)
//   busy                  : work in flight (stage 1, FIFO or clear)
//   clearing              : clear writes in progress
//   overflow              : sticky, a pixel was dropped on a full FIFO
//   clip_count            : saturating count of off-screen points
//   clr_stats             : zero overflow and clip_count
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int SCREEN_W   = PW_SCREEN_W,
  parameter int SCREEN_H   = PW_SCREEN_H,
  parameter int ADDR_W     = PW_ADDR_W,
  parameter int COLOR_W    = PW_COLOR_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               plot,
  input  Point2D             point,
  input  logic [COLOR_W-1:0] color,
  input  logic               clear_start,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  input  logic               mem_ack,
  output logic               busy,
  output logic               clearing,
  output logic               overflow,
  output logic [15:0]        clip_count,
  input  logic               clr_stats
);
  localparam int ENTRY_W = ADDR_W + COLOR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

  // ---------------- stage 1: clip and address ----------------
  logic               on_scr;
  logic               clip_evt;
  logic [ADDR_W-1:0]  lin_addr;
  logic               s1_valid;
  logic [ADDR_W-1:0]  s1_addr;
  logic [COLOR_W-1:0] s1_color;

  assign on_scr   = on_screen(point.x, point.y, SCREEN_W, SCREEN_H);
  assign clip_evt = plot && !on_scr;
  assign lin_addr = ADDR_W'(int'(point.y) * SCREEN_W + int'(point.x));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_color <= '0;
    end else begin
      s1_valid <= plot && on_scr;
      if (plot && on_scr) begin
        s1_addr  <= lin_addr;
        s1_color <= color;
      end
    end
  end

  // ---------------- stage 2: FIFO ----------------
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ENTRY_W-1:0] fifo_next;
  logic [ENTRY_W-1:0] s1_entry;
  logic               drop_evt;

  PwState state;
  PwState state_d;

  logic retire;
  logic fifo_presented;

  assign s1_entry       = {s1_addr, s1_color};
  assign retire         = mem_we && mem_ack;
  // Outside CLEAR an asserted mem_we always carries the FIFO head.
  assign fifo_presented = mem_we && (state != CLEAR);
  assign fifo_pop       = fifo_presented && mem_ack;
  assign fifo_push      = s1_valid && (!fifo_full || fifo_pop);
  assign drop_evt       = s1_valid && !fifo_push;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (s1_entry),
    .rd_data (fifo_head),
    .rd_next (fifo_next),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ---------------- statistics ----------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow   <= 1'b0;
      clip_count <= '0;
    end else if (clr_stats) begin
      overflow   <= 1'b0;
      clip_count <= '0;
    end else begin
      if (drop_evt) overflow <= 1'b1;
      if (clip_evt && (clip_count != 16'hFFFF)) clip_count <= clip_count + 16'd1;
    end
  end

  // ---------------- write port / FSM ----------------
  // The presented write stays in the FIFO until its ack, so the entry to
  // present next is the one that will be at the head after this edge:
  // the second entry when popping, else the head, else the entry being
  // pushed right now (bypass that gives the two-cycle plot-to-write path).
  logic               has_next;
  logic               cand_valid;
  logic [ENTRY_W-1:0] cand_entry;

  always_comb begin
    has_next   = fifo_pop ? (fifo_count > CNT_ONE) : !fifo_empty;
    cand_valid = has_next || fifo_push;
    cand_entry = s1_entry;
    if (has_next) cand_entry = fifo_pop ? fifo_next : fifo_head;
  end

  logic               we_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [COLOR_W-1:0] data_d;
  logic               latch_clear;
  logic [COLOR_W-1:0] clear_color_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= RUN;
    else        state <= state_d;
  end

  // During CLEAR mem_addr itself serves as the clear address counter.
  always_comb begin
    state_d     = state;
    we_d        = mem_we;
    addr_d      = mem_addr;
    data_d      = mem_data;
    latch_clear = 1'b0;
    case (state)
      RUN: begin
        if (clear_start) begin
          state_d     = CLEAR_WAIT;
          latch_clear = 1'b1;
          if (retire) we_d = 1'b0;
        end else if (!mem_we || retire) begin
          we_d = cand_valid;
          if (cand_valid) {addr_d, data_d} = cand_entry;
        end
      end
      CLEAR_WAIT: begin
        if (!mem_we || retire) begin
          state_d = CLEAR;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = clear_color_q;
        end
      end
      CLEAR: begin
        if (retire) begin
          if (mem_addr == LAST_ADDR) begin
            state_d = RUN;
            we_d    = cand_valid;
            if (cand_valid) {addr_d, data_d} = cand_entry;
          end else begin
            addr_d = mem_addr + ADDR_ONE;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= '0;
      clear_color_q <= '0;
    end else begin
      mem_we   <= we_d;
      mem_addr <= addr_d;
      mem_data <= data_d;
      if (latch_clear) clear_color_q <= clear_color;
    end
  end

  assign busy     = s1_valid || !fifo_empty || (state != RUN);
  assign clearing = (state == CLEAR);

endmodule

// File: tb/tb_pixel_writer.sv
module tb_pixel_writer;
  import pixel_writer_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        plot = 1'b0;
  Point2D      pt;
  logic [7:0]  color = '0;
  logic        clear_start = 1'b0;
  logic [7:0]  clear_color = '0;
  logic        mem_ack = 1'b0;
  logic        clr_stats = 1'b0;

  // 640x480 instance
  logic        b_we, b_busy, b_clearing, b_overflow;
  logic [18:0] b_addr;
  logic [7:0]  b_data;
  logic [15:0] b_clip;
  // 4x2 instance for the clear scenarios
  logic        s_we, s_busy, s_clearing, s_overflow;
  logic [18:0] s_addr;
  logic [7:0]  s_data;
  logic [15:0] s_clip;

  pixel_writer #(.SCREEN_W(640), .SCREEN_H(480), .ADDR_W(19), .COLOR_W(8), .FIFO_DEPTH(8)) dut (
    .clk(clk), .n_rst(n_rst), .plot(plot), .point(pt), .color(color),
    .clear_start(clear_start), .clear_color(clear_color),
    .mem_we(b_we), .mem_addr(b_addr), .mem_data(b_data), .mem_ack(mem_ack),
    .busy(b_busy), .clearing(b_clearing), .overflow(b_overflow),
    .clip_count(b_clip), .clr_stats(clr_stats));

  pixel_writer #(.SCREEN_W(4), .SCREEN_H(2), .ADDR_W(19), .COLOR_W(8), .FIFO_DEPTH(8)) dut_s (
    .clk(clk), .n_rst(n_rst), .plot(plot), .point(pt), .color(color),
    .clear_start(clear_start), .clear_color(clear_color),
    .mem_we(s_we), .mem_addr(s_addr), .mem_data(s_data), .mem_ack(mem_ack),
    .busy(s_busy), .clearing(s_clearing), .overflow(s_overflow),
    .clip_count(s_clip), .clr_stats(clr_stats));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  FbWrite log_b[$];
  FbWrite log_s[$];

  // Record every retired write (mem_we and mem_ack both high) mid-cycle.
  always @(negedge clk) begin
    if (b_we && mem_ack) log_b.push_back('{addr: b_addr, color: b_data});
    if (s_we && mem_ack) log_s.push_back('{addr: s_addr, color: s_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_plot(input shortint x, input shortint y, input logic [7:0] c);
    pt.x  = x;
    pt.y  = y;
    color = c;
    plot  = 1'b1;
    tick();
    plot  = 1'b0;
  endtask

  shortint cx[4] = '{-16'sd1, 16'sd640, 16'sd0, 16'sd639};
  shortint cy[4] = '{16'sd0, 16'sd5, 16'sd480, 16'sd479};
  logic    ok;

  initial begin
    pt = '{x: 16'sd0, y: 16'sd0};
    tick(); tick();
    // reset values
    check("rst_we",       32'(b_we), 0);
    check("rst_addr",     32'(b_addr), 0);
    check("rst_data",     32'(b_data), 0);
    check("rst_busy",     32'(b_busy), 0);
    check("rst_clearing", 32'(b_clearing), 0);
    check("rst_overflow", 32'(b_overflow), 0);
    check("rst_clip",     32'(b_clip), 0);
    n_rst = 1'b1;
    tick();

    // basic write: (3,2) -> 2*640+3 = 1283, two-cycle latency, one cycle wide
    mem_ack = 1'b1;
    do_plot(16'sd3, 16'sd2, 8'h5A);
    check("basic_c1_we", 32'(b_we), 0);
    tick();
    check("basic_c2_we",   32'(b_we), 1);
    check("basic_c2_addr", 32'(b_addr), 1283);
    check("basic_c2_data", 32'(b_data), 'h5A);
    tick();
    check("basic_c3_we", 32'(b_we), 0);
    tick();

    // clipping: three off-screen points, one corner point 479*640+639
    log_b.delete();
    for (int i = 0; i < 4; i++) begin
      do_plot(cx[i], cy[i], 8'(8'h60 + i));
      tick(); tick();
    end
    tick(); tick(); tick();
    check("clip_nwrites", 32'(log_b.size()), 1);
    if (log_b.size() > 0) begin
      check("clip_addr",  32'(log_b[0].addr), 307199);
      check("clip_color", 32'(log_b[0].color), 'h63);
    end
    check("clip_count", 32'(b_clip), 3);
    check("clip_no_ovf", 32'(b_overflow), 0);

    // overflow: 10 plots with ack low, only 8 fit
    mem_ack = 1'b0;
    log_b.delete();
    for (int i = 0; i < 10; i++) begin
      do_plot(shortint'(i), 16'sd1, 8'(8'h80 + i));
      tick(); tick();
    end
    check("ovf_flag",    32'(b_overflow), 1);
    check("ovf_held_we", 32'(b_we), 1);
    check("ovf_held_addr", 32'(b_addr), 640);
    check("ovf_no_retire", 32'(log_b.size()), 0);
    mem_ack = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("ovf_nwrites", 32'(log_b.size()), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_b.size()) begin
        check("ovf_addr",  32'(log_b[i].addr), 32'(640 + i));
        check("ovf_color", 32'(log_b[i].color), 32'('h80 + i));
      end
    end
    check("ovf_idle", 32'(b_busy), 0);

    // clr_stats coinciding with a clip event: the clear wins
    clr_stats = 1'b1;
    do_plot(-16'sd5, 16'sd0, 8'h00);
    clr_stats = 1'b0;
    check("clr_overflow", 32'(b_overflow), 0);
    check("clr_clip_wins", 32'(b_clip), 0);
    do_plot(16'sd0, -16'sd1, 8'h00);
    check("clip_resume", 32'(b_clip), 1);
    tick();

    // handshake hold: (7,3) -> 1927, ack after 4 cycles
    mem_ack = 1'b0;
    do_plot(16'sd7, 16'sd3, 8'h3C);
    tick();
    check("hold_we", 32'(b_we), 1);
    check("hold_addr0", 32'(b_addr), 1927);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_we_kept", 32'(b_we), 1);
      check("hold_addr",    32'(b_addr), 1927);
      check("hold_data",    32'(b_data), 'h3C);
      check("hold_busy",    32'(b_busy), 1);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("hold_retired_we", 32'(b_we), 0);
    check("hold_popped",     32'(b_busy), 0);

    // clear on 4x2: pending pixel (1,1) -> 5 completes first
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    do_plot(16'sd1, 16'sd1, 8'h22);
    tick();
    check("clr_pend_we",   32'(s_we), 1);
    check("clr_pend_addr", 32'(s_addr), 5);
    clear_start = 1'b1;
    clear_color = 8'h11;
    tick();
    clear_start = 1'b0;
    clear_color = 8'h00;
    check("clrwait_we",       32'(s_we), 1);
    check("clrwait_addr",     32'(s_addr), 5);
    check("clrwait_clearing", 32'(s_clearing), 0);
    check("clrwait_busy",     32'(s_busy), 1);
    tick();
    check("clrwait_addr2", 32'(s_addr), 5);
    log_s.delete();
    mem_ack = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (s_clearing) begin ok = 1'b1; break; end
      tick();
    end
    check("clear_entered", 32'(ok), 1);
    tick(); tick();
    check("clear_mid", 32'(s_clearing), 1);
    do_plot(16'sd2, 16'sd0, 8'h33);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!s_busy) begin ok = 1'b1; break; end
      tick();
    end
    check("clear_done", 32'(ok), 1);
    check("clear_clearing_low", 32'(s_clearing), 0);
    check("clear_nwrites", 32'(log_s.size()), 10);
    if (log_s.size() == 10) begin
      check("clear_first_addr",  32'(log_s[0].addr), 5);
      check("clear_first_color", 32'(log_s[0].color), 'h22);
      for (int i = 0; i < 8; i++) begin
        check("clear_addr",  32'(log_s[i+1].addr), 32'(i));
        check("clear_color", 32'(log_s[i+1].color), 'h11);
      end
      check("clear_after_addr",  32'(log_s[9].addr), 2);
      check("clear_after_color", 32'(log_s[9].color), 'h33);
    end

    // reset in the middle of a clear
    clear_start = 1'b1;
    clear_color = 8'h55;
    tick();
    clear_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (s_clearing) begin ok = 1'b1; break; end
      tick();
    end
    check("rclr_entered", 32'(ok), 1);
    tick(); tick();
    check("rclr_mid", 32'(s_clearing), 1);
    n_rst = 1'b0;
    #1;
    check("rclr_we",       32'(s_we), 0);
    check("rclr_addr",     32'(s_addr), 0);
    check("rclr_data",     32'(s_data), 0);
    check("rclr_busy",     32'(s_busy), 0);
    check("rclr_clearing", 32'(s_clearing), 0);
    check("rclr_big_we",   32'(b_we), 0);
    tick();
    n_rst = 1'b1;
    tick();
    do_plot(16'sd0, 16'sd0, 8'h44);
    tick();
    check("post_rst_we",     32'(s_we), 1);
    check("post_rst_addr",   32'(s_addr), 0);
    check("post_rst_data",   32'(s_data), 'h44);
    check("post_rst_big_we", 32'(b_we), 1);
    check("post_rst_big_addr", 32'(b_addr), 0);
    tick();
    check("post_rst_done", 32'(s_we), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
